// File: rtl/regwrite_decoder_pipe_if.sv
// Request/enable bundle between the write-port arbiter and the register-file write stage.
// The master drives write requests and control; the slave returns the registered enables.
interface regwrite_decoder_pipe_if #(
    parameter int SEL_W = 5,
    parameter int CNT_W = 8
);
    localparam int N = 1 << SEL_W;

    logic             stall;
    logic             wr_en0;
    logic [SEL_W-1:0] wr_sel0;
    logic             wr_en1;
    logic [SEL_W-1:0] wr_sel1;
    logic             clr_cnt;
    logic [N-1:0]     we0;
    logic [N-1:0]     we1;
    logic [N-1:0]     we_any;
    logic             collision;
    logic [CNT_W-1:0] collision_cnt;

    modport master (
        output stall, wr_en0, wr_sel0, wr_en1, wr_sel1, clr_cnt,
        input  we0, we1, we_any, collision, collision_cnt
    );

    modport slave (
        input  stall, wr_en0, wr_sel0, wr_en1, wr_sel1, clr_cnt,
        output we0, we1, we_any, collision, collision_cnt
    );
endinterface

// File: rtl/regwrite_decoder_pipe.sv
// Registered one-hot write-enable decoder for two register-file write ports.
// Writes to ZERO_IDX are dropped; on a same-register conflict port 0 wins and a collision is counted.
module regwrite_decoder_pipe #(
    parameter int SEL_W    = 5,
    parameter int ZERO_IDX = 31,
    parameter int CNT_W    = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    regwrite_decoder_pipe_if.slave bus
);
    localparam int               N        = 1 << SEL_W;
    // An out-of-range ZERO_IDX turns masking off entirely rather than aliasing onto a real index.
    localparam logic             MASK_EN  = (ZERO_IDX < N);
    localparam logic [SEL_W-1:0] ZERO_SEL = SEL_W'(ZERO_IDX);

    function automatic logic is_zero(input logic [SEL_W-1:0] sel);
        is_zero = MASK_EN && (sel == ZERO_SEL);
    endfunction

    function automatic logic [N-1:0] decode(input logic en, input logic [SEL_W-1:0] sel);
        decode = en ? (N'(1) << sel) : '0;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        sat_inc = (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    // Stage p0: combinational decode and port arbitration
    logic [N-1:0] d0_p0;
    logic [N-1:0] d1_raw_p0;
    logic [N-1:0] d1_p0;
    logic         hit_p0;

    always_comb begin
        d0_p0     = decode(bus.wr_en0 && !is_zero(bus.wr_sel0), bus.wr_sel0);
        d1_raw_p0 = decode(bus.wr_en1 && !is_zero(bus.wr_sel1), bus.wr_sel1);
        hit_p0    = bus.wr_en0 && bus.wr_en1 && (bus.wr_sel0 == bus.wr_sel1)
                    && !is_zero(bus.wr_sel0);
        d1_p0     = hit_p0 ? '0 : d1_raw_p0;
    end

    // Stage p1: capture register and collision counter
    logic [N-1:0]     we0_p1;
    logic [N-1:0]     we1_p1;
    logic [N-1:0]     we_any_p1;
    logic             collision_p1;
    logic [CNT_W-1:0] cnt_p1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            we0_p1       <= '0;
            we1_p1       <= '0;
            we_any_p1    <= '0;
            collision_p1 <= 1'b0;
            cnt_p1       <= '0;
        end else if (!bus.stall) begin
            we0_p1       <= d0_p0;
            we1_p1       <= d1_p0;
            we_any_p1    <= d0_p0 | d1_p0;
            collision_p1 <= hit_p0;
            if (bus.clr_cnt) begin
                cnt_p1 <= '0;
            end else if (hit_p0) begin
                cnt_p1 <= sat_inc(cnt_p1);
            end
        end
    end

    assign bus.we0           = we0_p1;
    assign bus.we1           = we1_p1;
    assign bus.we_any        = we_any_p1;
    assign bus.collision     = collision_p1;
    assign bus.collision_cnt = cnt_p1;
endmodule

// File: tb/tb_regwrite_decoder_pipe.sv
// Directed bench for regwrite_decoder_pipe: default configuration plus a
// ZERO_IDX=32 / CNT_W=2 instance sharing the same stimulus.
module tb_regwrite_decoder_pipe;
    logic clk = 1'b0;
    logic reset_n = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    regwrite_decoder_pipe_if #(.SEL_W(5), .CNT_W(8)) ifa ();
    regwrite_decoder_pipe_if #(.SEL_W(5), .CNT_W(2)) ifb ();

    regwrite_decoder_pipe #(.SEL_W(5), .ZERO_IDX(31), .CNT_W(8)) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(ifa.slave)
    );
    regwrite_decoder_pipe #(.SEL_W(5), .ZERO_IDX(32), .CNT_W(2)) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(ifb.slave)
    );

    typedef struct {
        logic        en0;
        logic [4:0]  sel0;
        logic        en1;
        logic [4:0]  sel1;
        logic        clr;
        logic [31:0] we0;
        logic [31:0] we1;
        logic [31:0] any;
        logic        col;
        logic [7:0]  cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic en0, input logic [4:0] sel0, input logic en1,
                                input logic [4:0] sel1, input logic clr,
                                input logic [31:0] we0, input logic [31:0] we1,
                                input logic col, input logic [7:0] cnt);
        vec_t v;
        v.en0 = en0; v.sel0 = sel0; v.en1 = en1; v.sel1 = sel1; v.clr = clr;
        v.we0 = we0; v.we1 = we1; v.any = we0 | we1; v.col = col; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic en0, input logic [4:0] sel0, input logic en1,
                          input logic [4:0] sel1, input logic stall, input logic clr);
        ifa.wr_en0 = en0; ifa.wr_sel0 = sel0; ifa.wr_en1 = en1; ifa.wr_sel1 = sel1;
        ifa.stall = stall; ifa.clr_cnt = clr;
        ifb.wr_en0 = en0; ifb.wr_sel0 = sel0; ifb.wr_en1 = en1; ifb.wr_sel1 = sel1;
        ifb.stall = stall; ifb.clr_cnt = clr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic [31:0] we0, input logic [31:0] we1,
                         input logic col, input logic [7:0] cnt);
        chk({tag, " a.we0"}, ifa.we0, we0);
        chk({tag, " a.we1"}, ifa.we1, we1);
        chk({tag, " a.we_any"}, ifa.we_any, we0 | we1);
        chk({tag, " a.collision"}, 32'(ifa.collision), 32'(col));
        chk({tag, " a.cnt"}, 32'(ifa.collision_cnt), 32'(cnt));
    endtask

    task automatic chk_b(input string tag, input logic [31:0] we0, input logic [31:0] we1,
                         input logic col, input logic [1:0] cnt);
        chk({tag, " b.we0"}, ifb.we0, we0);
        chk({tag, " b.we1"}, ifb.we1, we1);
        chk({tag, " b.we_any"}, ifb.we_any, we0 | we1);
        chk({tag, " b.collision"}, 32'(ifb.collision), 32'(col));
        chk({tag, " b.cnt"}, 32'(ifb.collision_cnt), 32'(cnt));
    endtask

    task automatic do_reset();
        set_in(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_a("reset", 32'h0, 32'h0, 1'b0, 8'd0);
        chk_b("reset", 32'h0, 32'h0, 1'b0, 2'd0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Default-configuration vector table, applied from a fresh reset.
        for (int i = 0; i < 31; i++)
            vecs.push_back(mk(1'b1, 5'(i), 1'b0, 5'd0, 1'b0, 32'd1 << i, 32'h0, 1'b0, 8'd0));
        vecs.push_back(mk(1'b1, 5'd31, 1'b1, 5'd31, 1'b0, 32'h0,  32'h0,   1'b0, 8'd0));
        vecs.push_back(mk(1'b1, 5'd7,  1'b1, 5'd7,  1'b0, 32'h80, 32'h0,   1'b1, 8'd1));
        vecs.push_back(mk(1'b1, 5'd7,  1'b1, 5'd9,  1'b0, 32'h80, 32'h200, 1'b0, 8'd1));
        vecs.push_back(mk(1'b0, 5'd0,  1'b1, 5'd31, 1'b0, 32'h0,  32'h0,   1'b0, 8'd1));
        vecs.push_back(mk(1'b1, 5'd5,  1'b1, 5'd31, 1'b0, 32'h20, 32'h0,   1'b0, 8'd1));
        vecs.push_back(mk(1'b0, 5'd4,  1'b1, 5'd4,  1'b0, 32'h0,  32'h10,  1'b0, 8'd1));
        vecs.push_back(mk(1'b1, 5'd0,  1'b1, 5'd0,  1'b0, 32'h1,  32'h0,   1'b1, 8'd2));
        vecs.push_back(mk(1'b1, 5'd2,  1'b0, 5'd0,  1'b1, 32'h4,  32'h0,   1'b0, 8'd0));

        reset_n = 1'b1;
        set_in(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        #2;
        do_reset();

        for (int i = 0; i < vecs.size(); i++) begin
            set_in(vecs[i].en0, vecs[i].sel0, vecs[i].en1, vecs[i].sel1, 1'b0, vecs[i].clr);
            tick();
            chk_a($sformatf("vec%0d", i), vecs[i].we0, vecs[i].we1, vecs[i].col, vecs[i].cnt);
        end

        // Register 31 is masked in dut_a but decodes normally (and collides) in dut_b.
        do_reset();
        set_in(1'b1, 5'd31, 1'b1, 5'd31, 1'b0, 1'b0);
        tick();
        chk_a("zero31", 32'h0, 32'h0, 1'b0, 8'd0);
        chk_b("zero31", 32'h8000_0000, 32'h0, 1'b1, 2'd1);

        // Stall holds every output and the counter; released inputs capture next edge.
        do_reset();
        set_in(1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        chk_a("stall_pre", 32'h8, 32'h0, 1'b0, 8'd0);
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 5'(6 + i), 1'b1, 5'(6 + i), 1'b1, 1'b0);
            tick();
            chk_a($sformatf("stall%0d", i), 32'h8, 32'h0, 1'b0, 8'd0);
        end
        set_in(1'b1, 5'd6, 1'b1, 5'd6, 1'b0, 1'b0);
        tick();
        chk_a("stall_rel", 32'h40, 32'h0, 1'b1, 8'd1);

        // Stall with a collision already captured keeps collision high.
        set_in(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
        tick();
        chk_a("stall_col", 32'h40, 32'h0, 1'b1, 8'd1);

        // Two-bit counter saturates at 3; clear beats a simultaneous collision.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_in(1'b1, 5'd1, 1'b1, 5'd1, 1'b0, 1'b0);
            tick();
            chk_b($sformatf("sat%0d", i), 32'h2, 32'h0, 1'b1, (i < 3) ? 2'(i + 1) : 2'd3);
        end
        set_in(1'b1, 5'd1, 1'b1, 5'd1, 1'b0, 1'b1);
        tick();
        chk_b("clr_hit", 32'h2, 32'h0, 1'b1, 2'd0);
        chk_a("clr_hit", 32'h2, 32'h0, 1'b1, 8'd0);

        // Asynchronous reset between edges clears outputs before the next edge.
        do_reset();
        set_in(1'b1, 5'd2, 1'b1, 5'd2, 1'b0, 1'b0);
        tick();
        set_in(1'b1, 5'd4, 1'b1, 5'd4, 1'b0, 1'b0);
        tick();
        chk_a("pre_arst", 32'h10, 32'h0, 1'b1, 8'd2);
        #2;
        reset_n = 1'b0;
        #1;
        chk_a("arst", 32'h0, 32'h0, 1'b0, 8'd0);
        tick();
        chk_a("arst_hold", 32'h0, 32'h0, 1'b0, 8'd0);
        @(negedge clk);
        reset_n = 1'b1;
        set_in(1'b1, 5'd8, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        chk_a("post_arst", 32'h100, 32'h0, 1'b0, 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
